sb_cmd_initiator: RTL and testbench

- System-bus initiator: the requesting end of the req/write_enable/addr/write_data/read_data/ready protocol that peripheral controllers (timer, etc.) answer as responders.
- Buffers CMD_DEPTH commands from an upstream valid/ready port and issues them on the bus strictly one at a time, in order.
- Returns one response pulse per completed transaction.
- Used to program peripherals in hardware, for example boot-time timer setup, without the core.

---
 rtl/sb_cmd_initiator.sv | 156 +++++++++++++++
 tb/tb_sb_cmd_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cmd_initiator.sv
// System-bus initiator: buffers upstream commands in a FIFO and issues them one at a time.
// Optional wait-for-ready timeout is enabled by defining SB_TIMEOUT_EN.
module sb_cmd_initiator #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        req_o,
  output logic        write_enable_o,
  output logic [31:0] addr_o,
  output logic [31:0] write_data_o,
  input  logic [31:0] read_data_i,
  input  logic        ready_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(CMD_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [64:0] fifo_mem [CMD_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop;
  logic [64:0] head;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid_i && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
  end

`ifdef SB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SB_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          we_d    = head[64];
          addr_d  = head[63:32];
          wdata_d = head[64] ? head[31:0] : 32'd0;
`ifdef SB_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end
      end
      ISSUE: begin
        if (ready_i) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'd0 : read_data_i;
`ifdef SB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
`ifdef SB_TIMEOUT_EN
      tmo_q       <= 16'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o    = !full;
  assign req_o          = req_q;
  assign write_enable_o = we_q;
  assign addr_o         = addr_q;
  assign write_data_o   = wdata_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign busy_o         = !empty || (state_q == ISSUE);
`ifdef SB_TIMEOUT_EN
  assign rsp_err_o      = rsp_err_q;
`else
  assign rsp_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sb_cmd_initiator.sv
// Scoreboard bench for sb_cmd_initiator: expected bus transactions and responses are queued at
// stimulus time and checked by independent monitors; a bench responder answers the bus.
module tb_sb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_i, cmd_valid_i, cmd_we_i, ready_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i, read_data_i;
  logic        cmd_ready_o, req_o, write_enable_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [31:0] addr_o, write_data_o, rsp_rdata_o;

  always #5 clk = ~clk;

  sb_cmd_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .req_o(req_o), .write_enable_o(write_enable_o), .addr_o(addr_o),
    .write_data_o(write_data_o), .read_data_i(read_data_i), .ready_i(ready_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int waits; logic [31:0] rdata; } resp_t;

  bus_t  bus_q[$];
  rsp_t  rsp_q[$];
  resp_t resp_q[$];

  int vectors = 0;
  int miscompares = 0;
  logic stall = 1'b0;
  logic chk_gap = 1'b0;
  int last_req_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: counts wait cycles per transaction, then pulses ready with read data.
  initial begin
    bit r_active = 0;
    int r_wait = 0;
    ready_i = 1'b0;
    read_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_i || !req_o) begin
        if (r_active && resp_q.size() > 0) void'(resp_q.pop_front());
        r_active = 0;
        ready_i = 1'b0;
        read_data_i = 32'd0;
      end else if (!stall && !ready_i) begin
        if (!r_active) begin
          r_active = 1;
          r_wait = (resp_q.size() > 0) ? resp_q[0].waits : 0;
        end
        if (r_wait == 0) begin
          ready_i = 1'b1;
          read_data_i = (resp_q.size() > 0) ? resp_q[0].rdata : 32'd0;
          if (resp_q.size() > 0) void'(resp_q.pop_front());
          r_active = 0;
        end else begin
          r_wait--;
        end
      end
    end
  end

  // Bus monitor: checks each new request, its stability, and the gap between requests.
  initial begin
    logic prev_req = 1'b0;
    bus_t cur;
    bus_t exp;
    int hi_len = 0;
    int low_cnt = 0;
    forever begin
      @(negedge clk);
      if (req_o && !prev_req) begin
        cur = '{write_enable_o, addr_o, write_data_o};
        hi_len = 1;
        if (chk_gap) chk("req_gap", low_cnt, 1);
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          exp = bus_q.pop_front();
          chk("bus_we", cur.we, exp.we);
          chk("bus_addr", cur.addr, exp.addr);
          chk("bus_wdata", cur.wdata, exp.wdata);
        end
      end else if (req_o) begin
        hi_len++;
        if (write_enable_o !== cur.we || addr_o !== cur.addr || write_data_o !== cur.wdata)
          chk("bus_stable", 0, 1);
      end else begin
        if (prev_req) begin
          last_req_len = hi_len;
          low_cnt = 0;
        end
        low_cnt++;
      end
      prev_req = req_o;
    end
  end

  // Response monitor.
  initial begin
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, exp.rdata);
          chk("rsp_err", rsp_err_o, exp.err);
        end
      end
    end
  end

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rdata, input logic err);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) chk("push_timeout", 0, 1);
    bus_q.push_back('{we, addr, we ? wdata : 32'd0});
    rsp_q.push_back('{(we || err) ? 32'd0 : rdata, err});
    resp_q.push_back('{waits, rdata});
    cmd_valid_i = 1'b1;
    cmd_we_i = we;
    cmd_addr_i = addr;
    cmd_wdata_i = wdata;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy_o || rsp_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int rsp_at;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_addr_i = 32'd0;
    cmd_wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req", req_o, 0);
    chk("rst_we", write_enable_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", write_data_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);

    // Single write, responder ready immediately; rsp visible on 3rd negedge after push edge.
    push(1'b1, 32'h8, 32'd10, 0, 32'h0, 1'b0);
    rsp_at = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (rsp_valid_o && rsp_at == 0) rsp_at = k;
    end
    chk("write_latency", rsp_at, 3);
    chk("write_req_len", last_req_len, 1);
    wait_idle();

    // Read with 3 wait cycles; data held afterwards.
    push(1'b0, 32'h0, 32'hDEAD_BEEF, 3, 32'h1234_5678, 1'b0);
    wait_idle();
    chk("read_req_len", last_req_len, 4);
    repeat (3) @(negedge clk);
    chk("read_hold", rsp_rdata_o, 32'h1234_5678);
    chk("addr_hold", addr_o, 32'h0);

    // Fill FIFO while stalled, then drain back-to-back.
    stall = 1'b1;
    push(1'b1, 32'h08, 32'h11, 0, 32'h0, 1'b0);
    push(1'b0, 32'h14, 32'h0, 1, 32'hA5A5_0014, 1'b0);
    push(1'b1, 32'h10, 32'h33, 0, 32'h0, 1'b0);
    push(1'b0, 32'h24, 32'h0, 2, 32'h0000_0024, 1'b0);
    push(1'b1, 32'h00, 32'h55, 0, 32'h0, 1'b0);
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready_o, 0);
    chk("full_busy", busy_o, 1);
    chk_gap = 1'b1;
    stall = 1'b0;
    wait_idle();
    chk_gap = 1'b0;
    chk("drain_busy", busy_o, 0);
    chk("drain_cmd_ready", cmd_ready_o, 1);

    // Reset mid-transaction with two commands queued.
    stall = 1'b1;
    push(1'b1, 32'h40, 32'h1, 0, 32'h0, 1'b0);
    push(1'b1, 32'h44, 32'h2, 0, 32'h0, 1'b0);
    push(1'b1, 32'h48, 32'h3, 0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre_rst_req", req_o, 1);
    rst_i = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    resp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_req", req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 1);
    chk("midrst_rdata", rsp_rdata_o, 0);
    stall = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy_o, 0);

`ifdef SB_TIMEOUT_EN
    // Never-ready responder times out; next command is normal; ready on timeout edge wins.
    push(1'b1, 32'h50, 32'h7, 20, 32'h0, 1'b1);
    wait_idle();
    chk("tmo_req_len", last_req_len, 8);
    push(1'b1, 32'h54, 32'h8, 0, 32'h0, 1'b0);
    wait_idle();
    push(1'b0, 32'h58, 32'h0, 7, 32'hCAFE_0001, 1'b0);
    wait_idle();
    chk("tmo_tie_req_len", last_req_len, 8);
`endif

    chk("sb_empty", bus_q.size() + rsp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
